// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I control path: sequencer
// states, base opcodes and the encodings of every datapath select driven
// by the controller. The immediate generator and ALU decoder import the
// same package so all three agree on the encodings.
package core_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH,
    ST_DECODE,
    ST_MEM_ADR,
    ST_MEM_RD,
    ST_MEM_WB,
    ST_MEM_WR,
    ST_EXEC_R,
    ST_EXEC_I,
    ST_LUI,
    ST_AUIPC,
    ST_ALU_WB,
    ST_BRANCH,
    ST_JAL,
    ST_JALR_ADR,
    ST_JALR_JMP,
    ST_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [2:0] IMM_I    = 3'd0;
  localparam logic [2:0] IMM_S    = 3'd1;
  localparam logic [2:0] IMM_B    = 3'd2;
  localparam logic [2:0] IMM_U    = 3'd3;
  localparam logic [2:0] IMM_J    = 3'd4;
  localparam logic [2:0] IMM_NONE = 3'd7;

  localparam logic [1:0] SRC_A_PC     = 2'd0;
  localparam logic [1:0] SRC_A_OLD_PC = 2'd1;
  localparam logic [1:0] SRC_A_RS1    = 2'd2;
  localparam logic [1:0] SRC_A_ZERO   = 2'd3;

  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_IMM  = 2'd1;
  localparam logic [1:0] SRC_B_FOUR = 2'd2;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] RES_ALU_OUT = 2'd0;
  localparam logic [1:0] RES_MEM     = 2'd1;
  localparam logic [1:0] RES_ALU     = 2'd2;

  // Immediate format implied by the base opcode.
  function automatic logic [2:0] imm_type_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_AUIPC, OP_LUI:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/instr_counter.sv
// Retired-instruction counter: increments by one on each clock where inc
// is high, wrapping modulo 2^WIDTH; asynchronous active-high clear.
// Ports: clk, reset, inc (count enable), count (current value).
module instr_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (inc) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Main sequencer of the multi-cycle RV32I core. Steps each instruction
// through fetch/decode/execute/memory/writeback and drives all datapath
// enables and mux selects, the immediate-format select, the memory
// handshake, a sticky illegal-opcode flag and a retired-instruction count.
// Ports:
//   clk, reset (async, active-high)
//   opcode, funct3, branch_taken, mem_ready            - inputs
//   pc_write, adr_src, mem_read, mem_write, ir_write,
//   reg_write, alu_src_a, alu_src_b, alu_op, result_src - datapath controls
//   imm_type                                            - immediate format
//   illegal_instr, instr_retired, instret               - status
module multicycle_control_fsm
  import core_ctrl_pkg::*;
#(
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 branch_taken,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 adr_src,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_type,
  output logic                 illegal_instr,
  output logic                 instr_retired,
  output logic [INSTRET_W-1:0] instret
);

  state_t state, state_next;

  // funct3 is consumed by the ALU decoder; sequencing depends on opcode only.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_FETCH;
      illegal_instr <= 1'b0;
    end else begin
      state <= state_next;
      if (state == ST_TRAP) begin
        illegal_instr <= 1'b1;
      end
    end
  end

  // Outputs are forced inactive while reset is asserted, so the controls
  // are quiet even when reset lands in the middle of a memory access.
  always_comb begin
    state_next    = state;
    pc_write      = 1'b0;
    adr_src       = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_RS2;
    alu_op        = ALU_ADD;
    result_src    = RES_ALU_OUT;
    instr_retired = 1'b0;
    imm_type      = reset ? IMM_NONE : imm_type_of(opcode);

    if (!reset) begin
      case (state)
        ST_FETCH: begin
          mem_read   = 1'b1;
          alu_src_a  = SRC_A_PC;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            state_next = ST_DECODE;
          end
        end
        ST_DECODE: begin
          alu_src_a = SRC_A_OLD_PC;
          alu_src_b = SRC_B_IMM;
          case (opcode)
            OP_LOAD, OP_STORE: state_next = ST_MEM_ADR;
            OP_REG:            state_next = ST_EXEC_R;
            OP_IMM:            state_next = ST_EXEC_I;
            OP_LUI:            state_next = ST_LUI;
            OP_AUIPC:          state_next = ST_AUIPC;
            OP_BRANCH:         state_next = ST_BRANCH;
            OP_JAL:            state_next = ST_JAL;
            OP_JALR:           state_next = ST_JALR_ADR;
            default:           state_next = ST_TRAP;
          endcase
        end
        ST_MEM_ADR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          state_next = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
        end
        ST_MEM_RD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
          if (mem_ready) begin
            state_next = ST_MEM_WB;
          end
        end
        ST_MEM_WB: begin
          reg_write     = 1'b1;
          result_src    = RES_MEM;
          instr_retired = 1'b1;
          state_next    = ST_FETCH;
        end
        ST_MEM_WR: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
          if (mem_ready) begin
            instr_retired = 1'b1;
            state_next    = ST_FETCH;
          end
        end
        ST_EXEC_R: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_RS2;
          alu_op     = ALU_FUNCT;
          state_next = ST_ALU_WB;
        end
        ST_EXEC_I: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          alu_op     = ALU_FUNCT;
          state_next = ST_ALU_WB;
        end
        ST_LUI: begin
          alu_src_a  = SRC_A_ZERO;
          alu_src_b  = SRC_B_IMM;
          state_next = ST_ALU_WB;
        end
        ST_AUIPC: begin
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_IMM;
          state_next = ST_ALU_WB;
        end
        ST_ALU_WB: begin
          reg_write     = 1'b1;
          result_src    = RES_ALU_OUT;
          instr_retired = 1'b1;
          state_next    = ST_FETCH;
        end
        ST_BRANCH: begin
          alu_src_a     = SRC_A_RS1;
          alu_src_b     = SRC_B_RS2;
          alu_op        = ALU_SUB;
          result_src    = RES_ALU_OUT;
          pc_write      = branch_taken;
          instr_retired = 1'b1;
          state_next    = ST_FETCH;
        end
        // JAL/JALR_JMP: ALUOut holds the target computed one state earlier
        // while the ALU forms the link address OldPC+4 for ALU_WB.
        ST_JAL, ST_JALR_JMP: begin
          pc_write   = 1'b1;
          result_src = RES_ALU_OUT;
          alu_src_a  = SRC_A_OLD_PC;
          alu_src_b  = SRC_B_FOUR;
          state_next = ST_ALU_WB;
        end
        ST_JALR_ADR: begin
          alu_src_a  = SRC_A_RS1;
          alu_src_b  = SRC_B_IMM;
          state_next = ST_JALR_JMP;
        end
        ST_TRAP: begin
          state_next = ST_TRAP;
        end
      endcase
    end
  end

  instr_counter #(
    .WIDTH(INSTRET_W)
  ) u_instr_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (instr_retired),
    .count (instret)
  );

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed per-cycle checks of the
// instruction flows plus a randomized instruction stream with a reactive
// memory responder, checked against per-instruction-class expectations.
module tb_multicycle_control_fsm;

  localparam int unsigned IW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic [2:0]    funct3;
  logic          branch_taken;
  logic          mem_ready;
  logic          pc_write, adr_src, mem_read, mem_write, ir_write, reg_write;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic [2:0]    imm_type;
  logic          illegal_instr, instr_retired;
  logic [IW-1:0] instret;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned exp_instret = 0;

  typedef struct packed {
    logic       pcw, adr, mr, mw, irw, rw;
    logic [1:0] a, b, op, rs;
    logic       ret;
  } ctl_t;

  ctl_t obs;
  assign obs = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write,
                alu_src_a, alu_src_b, alu_op, result_src, instr_retired};

  multicycle_control_fsm #(.INSTRET_W(IW)) dut (
    .clk           (clk),
    .reset         (reset),
    .opcode        (opcode),
    .funct3        (funct3),
    .branch_taken  (branch_taken),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .adr_src       (adr_src),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .result_src    (result_src),
    .imm_type      (imm_type),
    .illegal_instr (illegal_instr),
    .instr_retired (instr_retired),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  function automatic ctl_t c(input logic pcw, adr, mr, mw, irw, rw,
                             input logic [1:0] a, b, op, rs, input logic ret);
    ctl_t t;
    t = '{pcw, adr, mr, mw, irw, rw, a, b, op, rs, ret};
    return t;
  endfunction

  // Phase expectations straight from the control table.
  function automatic ctl_t fetch_go();  return c(1,0,1,0,1,0, 2'd0,2'd2,2'd0,2'd2, 0); endfunction
  function automatic ctl_t fetch_wt();  return c(0,0,1,0,0,0, 2'd0,2'd2,2'd0,2'd2, 0); endfunction
  function automatic ctl_t decode();    return c(0,0,0,0,0,0, 2'd1,2'd1,2'd0,2'd0, 0); endfunction
  function automatic ctl_t rs1_imm();   return c(0,0,0,0,0,0, 2'd2,2'd1,2'd0,2'd0, 0); endfunction
  function automatic ctl_t alu_wb();    return c(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd0, 1); endfunction

  function automatic logic [2:0] exp_imm(input logic [6:0] op);
    case (op)
      7'd3, 7'd19, 7'd103: return 3'd0;
      7'd35:               return 3'd1;
      7'd99:               return 3'd2;
      7'd23, 7'd55:        return 3'd3;
      7'd111:              return 3'd4;
      default:             return 3'd7;
    endcase
  endfunction

  function automatic int unsigned base_latency(input logic [6:0] op);
    case (op)
      7'd3, 7'd103: return 5;
      7'd99:        return 3;
      default:      return 4;
    endcase
  endfunction

  task automatic step(input logic [6:0] op, input logic rdy, input logic bt);
    @(negedge clk);
    opcode       = op;
    funct3       = 3'($urandom_range(0, 7));
    mem_ready    = rdy;
    branch_taken = bt;
    #1;
  endtask

  task automatic retire_edge(input string name);
    @(posedge clk);
    #1;
    exp_instret = (exp_instret + 1) % (1 << IW);
    checks++;
    if (instret !== IW'(exp_instret)) begin
      failures++;
      $display("FAIL %s_instret got=%0d exp=%0d", name, instret, exp_instret);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; opcode = 7'd51; funct3 = '0; mem_ready = 1'b1; branch_taken = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (obs !== ctl_t'('0) || imm_type !== 3'd7 || instret !== '0 || illegal_instr !== 1'b0) begin
      failures++;
      $display("FAIL reset_state ctl=%h imm=%0d instret=%0d ill=%b exp ctl=0 imm=7 instret=0 ill=0",
               obs, imm_type, instret, illegal_instr);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    exp_instret = 0;
  endtask

  task automatic test_add;
    ctl_t exp [4];
    exp = '{fetch_go(), decode(), c(0,0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0, 0), alu_wb()};
    for (int i = 0; i < 4; i++) begin
      step(7'd51, 1'b1, 1'b0);
      checks++;
      if (obs !== exp[i]) begin
        failures++;
        $display("FAIL add_cycle%0d ctl got=%h exp=%h", i, obs, exp[i]);
      end
    end
    retire_edge("add");
  endtask

  task automatic test_lw_stall;
    ctl_t exp [8];
    logic rdy [8];
    ctl_t mem_rd;
    mem_rd = c(0,1,1,0,0,0, 2'd0,2'd0,2'd0,2'd0, 0);
    exp = '{fetch_go(), decode(), rs1_imm(), mem_rd, mem_rd, mem_rd, mem_rd,
            c(0,0,0,0,0,1, 2'd0,2'd0,2'd0,2'd1, 1)};
    rdy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 8; i++) begin
      step(7'd3, rdy[i], 1'b0);
      checks++;
      if (obs !== exp[i] || imm_type !== 3'd0) begin
        failures++;
        $display("FAIL lw_cycle%0d ctl got=%h exp=%h imm got=%0d exp=0", i, obs, exp[i], imm_type);
      end
    end
    retire_edge("lw");
  endtask

  task automatic test_beq;
    ctl_t exp [3];
    for (int t = 0; t < 2; t++) begin
      exp = '{fetch_go(), decode(), c(t[0],0,0,0,0,0, 2'd2,2'd0,2'd1,2'd0, 1)};
      for (int i = 0; i < 3; i++) begin
        step(7'd99, 1'b1, t[0]);
        checks++;
        if (obs !== exp[i] || imm_type !== 3'd2) begin
          failures++;
          $display("FAIL beq_taken%0d_cycle%0d ctl got=%h exp=%h imm got=%0d exp=2",
                   t, i, obs, exp[i], imm_type);
        end
      end
      retire_edge("beq");
    end
  endtask

  task automatic test_jalr;
    ctl_t exp [5];
    exp = '{fetch_go(), decode(), rs1_imm(), c(1,0,0,0,0,0, 2'd1,2'd2,2'd0,2'd0, 0), alu_wb()};
    for (int i = 0; i < 5; i++) begin
      step(7'd103, 1'b1, 1'b0);
      checks++;
      if (obs !== exp[i] || imm_type !== 3'd0) begin
        failures++;
        $display("FAIL jalr_cycle%0d ctl got=%h exp=%h imm got=%0d exp=0", i, obs, exp[i], imm_type);
      end
    end
    retire_edge("jalr");
  endtask

  // Random legal instructions; memory holds mem_ready low for a chosen
  // number of cycles at the start of each access (fetch, then data).
  task automatic test_random;
    logic [6:0] ops [9];
    ops = '{7'd3, 7'd19, 7'd23, 7'd35, 7'd51, 7'd55, 7'd99, 7'd103, 7'd111};
    for (int n = 0; n < 40; n++) begin
      logic [6:0]  op;
      int unsigned f, d, wait_left, cyc, n_mr, n_mw, n_adr, n_rw, n_pcw, n_irw, imm_err;
      int unsigned e_cyc, e_mr, e_mw, e_adr, e_rw, e_pcw;
      logic bt, in_acc, first_acc, done, is_ld, is_st;
      op = ops[$urandom_range(0, 8)];
      f = $urandom_range(0, 3);
      d = $urandom_range(0, 3);
      bt = 1'($urandom_range(0, 1));
      is_ld = (op == 7'd3);
      is_st = (op == 7'd35);
      {cyc, n_mr, n_mw, n_adr, n_rw, n_pcw, n_irw, imm_err, wait_left} = '0;
      in_acc = 1'b0; first_acc = 1'b1; done = 1'b0;
      while (!done && cyc < 30) begin
        @(negedge clk);
        opcode = op; branch_taken = bt; mem_ready = 1'b0;
        funct3 = 3'($urandom_range(0, 7));
        #1;
        if (mem_read || mem_write) begin
          if (!in_acc) begin
            in_acc = 1'b1;
            wait_left = first_acc ? f : d;
            first_acc = 1'b0;
          end
          if (wait_left > 0) wait_left--;
          else begin
            mem_ready = 1'b1;
            in_acc = 1'b0;
          end
        end
        #1;
        cyc++;
        n_mr += mem_read; n_mw += mem_write; n_adr += adr_src;
        n_rw += reg_write; n_pcw += pc_write; n_irw += ir_write;
        if (imm_type !== exp_imm(op)) imm_err++;
        if (instr_retired) done = 1'b1;
      end
      e_cyc = base_latency(op) + f + ((is_ld || is_st) ? d : 0);
      e_mr  = f + 1 + (is_ld ? d + 1 : 0);
      e_mw  = is_st ? d + 1 : 0;
      e_adr = (is_ld || is_st) ? d + 1 : 0;
      e_rw  = (is_st || op == 7'd99) ? 0 : 1;
      e_pcw = 1 + ((op == 7'd99 && bt) ? 1 : 0) + ((op == 7'd111 || op == 7'd103) ? 1 : 0);
      checks++;
      if (!done || cyc != e_cyc || n_mr != e_mr || n_mw != e_mw || n_adr != e_adr ||
          n_rw != e_rw || n_pcw != e_pcw || n_irw != 1 || imm_err != 0) begin
        failures++;
        $display("FAIL rand%0d op=%0d f=%0d d=%0d bt=%b got cyc=%0d mr=%0d mw=%0d adr=%0d rw=%0d pcw=%0d irw=%0d immerr=%0d exp cyc=%0d mr=%0d mw=%0d adr=%0d rw=%0d pcw=%0d irw=1 immerr=0",
                 n, op, f, d, bt, cyc, n_mr, n_mw, n_adr, n_rw, n_pcw, n_irw, imm_err,
                 e_cyc, e_mr, e_mw, e_adr, e_rw, e_pcw);
      end
      if (done) retire_edge("rand");
    end
  endtask

  task automatic test_reset_mid_access;
    step(7'd3, 1'b1, 1'b0);
    step(7'd3, 1'b1, 1'b0);
    step(7'd3, 1'b1, 1'b0);
    step(7'd3, 1'b0, 1'b0);
    checks++;
    if (mem_read !== 1'b1 || adr_src !== 1'b1) begin
      failures++;
      $display("FAIL mid_rd_setup mem_read=%b adr_src=%b exp 1 1", mem_read, adr_src);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== ctl_t'('0) || imm_type !== 3'd7 || instret !== '0 || illegal_instr !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_rd ctl=%h imm=%0d instret=%0d ill=%b exp ctl=0 imm=7 instret=0 ill=0",
               obs, imm_type, instret, illegal_instr);
    end
    exp_instret = 0;
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if (obs !== fetch_wt()) begin
      failures++;
      $display("FAIL reset_to_fetch ctl got=%h exp=%h", obs, fetch_wt());
    end
  endtask

  task automatic test_trap;
    step(7'h7F, 1'b1, 1'b0);
    checks++;
    if (obs !== fetch_go()) begin
      failures++;
      $display("FAIL trap_fetch ctl got=%h exp=%h", obs, fetch_go());
    end
    step(7'h7F, 1'b1, 1'b0);
    step(7'h7F, 1'b1, 1'b0);
    checks++;
    if (obs !== ctl_t'('0) || imm_type !== 3'd7) begin
      failures++;
      $display("FAIL trap_entry ctl got=%h imm=%0d exp ctl=0 imm=7", obs, imm_type);
    end
    for (int i = 0; i < 10; i++) begin
      step(7'd51, 1'b1, 1'b1);
      checks++;
      if (illegal_instr !== 1'b1 || obs !== ctl_t'('0)) begin
        failures++;
        $display("FAIL trap_hold%0d ill got=%b exp=1 ctl got=%h exp=0", i, illegal_instr, obs);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (illegal_instr !== 1'b0 || instret !== '0) begin
      failures++;
      $display("FAIL trap_cleared ill got=%b instret got=%0d exp 0 0", illegal_instr, instret);
    end
    @(negedge clk);
    mem_ready = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_beq();
    test_jalr();
    test_random();
    test_reset_mid_access();
    test_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main sequencing controller for the multi-cycle RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, driving every datapath enable and mux select. It also drives the immediate-format select into the immediate generator. It handshakes with the unified instruction/data memory, and keeps a retired-instruction counter and a sticky illegal-opcode flag.

Parameters:
INSTRET_W, 32, width of retired-instruction counter (wraps modulo 2^INSTRET_W)

Ports:
clk  in  1  core clock, all state updates on rising edge
reset  in  1  asynchronous, active-high; clears state and counter immediately
opcode  in  7  IR[6:0] of the current instruction
funct3  in  3  IR[14:12]
branch_taken  in  1  comparator result for the current B-type funct3 (rs1 vs rs2)
mem_ready  in  1  memory completes the current read/write this cycle
pc_write  out  1  load PC from result bus
adr_src  out  1  memory address mux: 0=PC, 1=ALUOut
mem_read  out  1  memory read request
mem_write  out  1  memory write request
ir_write  out  1  latch IR and OldPC
reg_write  out  1  register-file write enable
alu_src_a  out  2  0=PC, 1=OldPC, 2=rs1, 3=zero
alu_src_b  out  2  0=rs2, 1=imm, 2=const 4
alu_op  out  2  0=ADD, 1=SUB/compare, 2=decode from funct3/funct7
result_src  out  2  0=ALUOut, 1=mem data, 2=ALU result (direct)
imm_type  out  3  0=I, 1=S, 2=B, 3=U, 4=J, 7=none
illegal_instr  out  1  sticky, set on unknown opcode
instr_retired  out  1  one-cycle pulse per completed instruction
instret  out  INSTRET_W  retired-instruction count

Behaviour:
- Moore FSM; all control outputs decode from the state register. mem_ready and branch_taken are the only same-cycle Mealy gating inputs.
- Reset (async, any time, including mid-memory-access):
  - state=FETCH, instret=0, illegal_instr=0.
  - While reset is high, all control outputs are 0 and imm_type=7.
- Every non-TRAP state defaults to 0 on enables/selects not listed below.
- imm_type is combinational from opcode in every state:
  - 3/19/103 -> I; 35 -> S; 99 -> B; 23/55 -> U; 111 -> J; else 7.
- FETCH: mem_read=1, adr_src=0, a=PC, b=4, ADD, result_src=2.
  - Hold while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1 (PC<=PC+4), go to DECODE.
- DECODE: a=OldPC, b=imm, ADD (branch/JAL target into ALUOut). Next state by opcode:
  - 3/35 -> MEM_ADR; 51 -> EXEC_R; 19 -> EXEC_I; 55 -> LUI; 23 -> AUIPC
  - 99 -> BRANCH; 111 -> JAL; 103 -> JALR_ADR; other -> TRAP
- MEM_ADR: a=rs1, b=imm, ADD -> MEM_RD if opcode=3, else MEM_WR.
- MEM_RD: mem_read=1, adr_src=1; hold until mem_ready -> MEM_WB.
- MEM_WB: reg_write=1, result_src=1 -> FETCH, retire.
- MEM_WR: mem_write=1, adr_src=1; hold until mem_ready -> FETCH, retire.
- EXEC_R: a=rs1, b=rs2, alu_op=2 -> ALU_WB.
- EXEC_I: a=rs1, b=imm, alu_op=2 -> ALU_WB.
- LUI: a=zero, b=imm, ADD -> ALU_WB.
- AUIPC: a=OldPC, b=imm, ADD -> ALU_WB.
- ALU_WB: reg_write=1, result_src=0 -> FETCH, retire.
- BRANCH: a=rs1, b=rs2, alu_op=1, result_src=0, pc_write=branch_taken -> FETCH, retire.
- JAL: pc_write=1, result_src=0 (target); a=OldPC, b=4, ADD (link) -> ALU_WB.
- JALR_ADR: a=rs1, b=imm, ADD -> JALR_JMP.
- JALR_JMP: pc_write=1, result_src=0; a=OldPC, b=4, ADD -> ALU_WB.
  - The datapath clears bit 0 of the JALR target; the controller does not.
- TRAP: illegal_instr<=1, all enables 0; remains until reset.
- Retire: instr_retired=1 for exactly the cycle the FSM leaves a retiring state; instret increments the following edge, wrapping at all-ones.
- Latencies with mem_ready tied high:
  - R, I, LUI, AUIPC: 4 cycles
  - load: 5; store: 4; branch: 3; JAL: 4; JALR: 5

Decomposition:
- Shared package core_ctrl_pkg holds:
  - state enum
  - opcode constants (3, 19, 23, 35, 51, 55, 99, 103, 111)
  - imm_type, alu_src_a/b, alu_op and result_src encodings
- The immediate generator and ALU decoder import the same package.
- One natural sub-module: instr_counter (INSTRET_W wrap counter with async reset).

Test Plan:
- Reset pulse asserted mid-MEM_RD -> state=FETCH on the same cycle; all enables 0; instret=0; illegal_instr=0.
- add (opcode 51), mem_ready=1 -> FETCH, DECODE, EXEC_R, ALU_WB; reg_write high only in cycle 4; instr_retired pulse; instret=1.
- lw (opcode 3) with mem_ready low 3 cycles in MEM_RD -> mem_read/adr_src=1 held 4 cycles; total 8 cycles; imm_type=0 throughout.
- beq (opcode 99): branch_taken=0 -> no pc_write in BRANCH; branch_taken=1 -> pc_write=1 in BRANCH; each takes 3 cycles; imm_type=2.
- jalr (opcode 103) -> JALR_ADR, JALR_JMP (pc_write=1), ALU_WB (reg_write=1); 5 cycles.
- opcode 0x7F -> TRAP; illegal_instr=1 and stays set for 10 cycles; no further mem_read until reset.
